conv_pe_seq: RTL

- Sequencer for one conv_pe MAC engine. Walks every output pixel of every output channel of a single-input-channel valid convolution (stride 1, no padding).
- Issues feature-map and weight read addresses and streams operands into the PE.
- Captures each PE result into an output buffer.
- Sits between the layer scheduler (go/done) and the fmap/weight/bias/output memories of a conv layer.

---
 rtl/conv_pe_seq_if.sv | 51 +++++
 rtl/conv_pe_seq.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/conv_pe_seq_if.sv
// ---------------------------------------------------------------------------
// conv_pe_seq_if
// Bundles every non-clock/reset signal of the conv_pe_seq sequencer: the
// scheduler handshake (go/busy/done), the feature-map, weight and bias memory
// ports, the operand/result path to the conv_pe MAC engine and the output
// buffer write port.
//   master : the sequencer (drives addresses, PE operands, output writes)
//   slave  : the surrounding layer (scheduler, memories, PE)
// Parameters must match the ones given to the conv_pe_seq instance.
// ---------------------------------------------------------------------------
interface conv_pe_seq_if #(
    parameter int FM_AW  = 10,
    parameter int W_AW   = 8,
    parameter int OUT_AW = 12,
    parameter int B_AW   = 3
);
    logic              go;
    logic              busy;
    logic              done;
    logic [FM_AW-1:0]  fm_addr;
    logic              fm_ren;
    logic [15:0]       fm_rdata;
    logic [W_AW-1:0]   w_addr;
    logic [15:0]       w_rdata;
    logic [B_AW-1:0]   b_addr;
    logic [15:0]       bias_in;
    logic [15:0]       pe_fm;
    logic [15:0]       pe_w;
    logic [15:0]       pe_bias;
    logic              pe_start;
    logic              pe_ready;
    logic [15:0]       pe_out;
    logic              pe_flag;
    logic              out_we;
    logic [OUT_AW-1:0] out_addr;
    logic [15:0]       out_wdata;

    modport master (
        input  go, fm_rdata, w_rdata, bias_in, pe_out, pe_flag,
        output busy, done, fm_addr, fm_ren, w_addr, b_addr,
               pe_fm, pe_w, pe_bias, pe_start, pe_ready,
               out_we, out_addr, out_wdata
    );

    modport slave (
        output go, fm_rdata, w_rdata, bias_in, pe_out, pe_flag,
        input  busy, done, fm_addr, fm_ren, w_addr, b_addr,
               pe_fm, pe_w, pe_bias, pe_start, pe_ready,
               out_we, out_addr, out_wdata
    );
endinterface

// File: rtl/conv_pe_seq.sv
// ---------------------------------------------------------------------------
// conv_pe_seq
// Sequencer for one conv_pe MAC engine. For a single-input-channel valid
// convolution (stride 1, no padding) it walks channel -> oy -> ox -> ky -> kx,
// issues feature-map/weight reads, streams the returned operands into the PE
// and writes every PE result into the output buffer.
// Ports:
//   clk, n_reset : clock, asynchronous active-low reset
//   bus (master) : go/busy/done handshake, fm/weight/bias memory ports,
//                  PE operand and result signals, output write port
// Timing: PRIME (dummy zero beat + tap-0 address), RUN (one beat per cycle,
// N_CH*NWIN*KK cycles), FLUSH (final PE flag), DONE (one-cycle pulse).
// ---------------------------------------------------------------------------
module conv_pe_seq #(
    parameter int IMG_W  = 28,
    parameter int K      = 3,
    parameter int N_CH   = 6,
    parameter int FM_AW  = 10,
    parameter int W_AW   = 8,
    parameter int OUT_AW = 12,
    parameter int B_AW   = 3
) (
    input  logic          clk,
    input  logic          n_reset,
    conv_pe_seq_if.master bus
);
    localparam int OUT_W = IMG_W - K + 1;
    localparam int KK    = K * K;
    localparam int NWIN  = OUT_W * OUT_W;
    localparam int NOUT  = N_CH * NWIN;
    localparam int KW    = (K > 1)    ? $clog2(K)    : 1;
    localparam int OW    = (OUT_W > 1)? $clog2(OUT_W): 1;
    localparam int CW    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int WW    = (NWIN > 1) ? $clog2(NWIN) : 1;

    typedef enum logic [2:0] {S_IDLE, S_PRIME, S_RUN, S_FLUSH, S_DONE} state_t;
    state_t state, state_nxt;

    // Read side: position of the beat whose address is currently issued.
    logic [KW-1:0]     kx, ky;
    logic [OW-1:0]     ox, oy;
    logic [CW-1:0]     ch;
    logic [FM_AW-1:0]  win_base;   // oy*IMG_W + ox
    logic [FM_AW-1:0]  row_base;   // (oy+ky)*IMG_W + ox
    logic [W_AW-1:0]   w_base;     // ch*KK
    logic [W_AW-1:0]   w_ptr;      // ch*KK + ky*K + kx

    // Write side: tracks the output being flagged, independent of reads.
    logic [WW-1:0]     wr_win;
    logic [B_AW-1:0]   b_ch;
    logic [OUT_AW-1:0] out_cnt;

    logic at_origin, busy, done_c, fm_ren_c, start_c, ready_c, feed, advance;
    logic out_we;

    // The read counters return to all-zero exactly once per layer, after the
    // last beat's successor has been "issued": that marks the final RUN cycle.
    assign at_origin = (kx == '0) && (ky == '0) && (ox == '0) && (oy == '0) && (ch == '0);

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done_c    = 1'b0;
        fm_ren_c  = 1'b0;
        start_c   = 1'b0;
        ready_c   = 1'b0;
        feed      = 1'b0;
        advance   = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.go) state_nxt = S_PRIME;
            end
            S_PRIME: begin
                // Dummy zero beat: the PE's first window takes KK+1 products.
                busy      = 1'b1;
                start_c   = 1'b1;
                ready_c   = 1'b1;
                fm_ren_c  = 1'b1;
                advance   = 1'b1;
                state_nxt = S_RUN;
            end
            S_RUN: begin
                busy    = 1'b1;
                start_c = 1'b1;
                ready_c = 1'b1;
                feed    = 1'b1;
                if (at_origin) begin
                    state_nxt = S_FLUSH;
                end else begin
                    fm_ren_c = 1'b1;
                    advance  = 1'b1;
                end
            end
            S_FLUSH: begin
                busy      = 1'b1;
                start_c   = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                done_c    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Read address walk; bases are stepped by addition, never multiplied.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            kx       <= '0;
            ky       <= '0;
            ox       <= '0;
            oy       <= '0;
            ch       <= '0;
            win_base <= '0;
            row_base <= '0;
            w_base   <= '0;
            w_ptr    <= '0;
        end else if (advance) begin
            if (kx != KW'(K - 1)) begin
                kx    <= kx + 1'b1;
                w_ptr <= w_ptr + 1'b1;
            end else if (ky != KW'(K - 1)) begin
                kx       <= '0;
                ky       <= ky + 1'b1;
                row_base <= row_base + FM_AW'(IMG_W);
                w_ptr    <= w_ptr + 1'b1;
            end else begin
                kx    <= '0;
                ky    <= '0;
                w_ptr <= w_base;
                if (ox != OW'(OUT_W - 1)) begin
                    ox       <= ox + 1'b1;
                    win_base <= win_base + FM_AW'(1);
                    row_base <= win_base + FM_AW'(1);
                end else if (oy != OW'(OUT_W - 1)) begin
                    // From (oy, OUT_W-1) to (oy+1, 0): +K lands on the next row.
                    ox       <= '0;
                    oy       <= oy + 1'b1;
                    win_base <= win_base + FM_AW'(K);
                    row_base <= win_base + FM_AW'(K);
                end else begin
                    ox       <= '0;
                    oy       <= '0;
                    win_base <= '0;
                    row_base <= '0;
                    if (ch != CW'(N_CH - 1)) begin
                        ch     <= ch + 1'b1;
                        w_base <= w_base + W_AW'(KK);
                        w_ptr  <= w_base + W_AW'(KK);
                    end else begin
                        ch     <= '0;
                        w_base <= '0;
                        w_ptr  <= '0;
                    end
                end
            end
        end
    end

    // Result capture: the bias channel moves on only after the flag of the
    // channel's last window, and all write counters wrap back to 0 at the end.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_win  <= '0;
            b_ch    <= '0;
            out_cnt <= '0;
        end else if (out_we) begin
            if (wr_win == WW'(NWIN - 1)) begin
                wr_win <= '0;
                b_ch   <= (b_ch == B_AW'(N_CH - 1)) ? '0 : b_ch + 1'b1;
            end else begin
                wr_win <= wr_win + 1'b1;
            end
            out_cnt <= (out_cnt == OUT_AW'(NOUT - 1)) ? '0 : out_cnt + 1'b1;
        end
    end

    assign out_we        = busy & bus.pe_flag;

    assign bus.busy      = busy;
    assign bus.done      = done_c;
    assign bus.fm_addr   = row_base + FM_AW'(kx);
    assign bus.fm_ren    = fm_ren_c;
    assign bus.w_addr    = w_ptr;
    assign bus.b_addr    = b_ch;
    assign bus.pe_fm     = feed ? bus.fm_rdata : '0;
    assign bus.pe_w      = feed ? bus.w_rdata  : '0;
    assign bus.pe_bias   = busy ? bus.bias_in  : '0;
    assign bus.pe_start  = start_c;
    assign bus.pe_ready  = ready_c;
    assign bus.out_we    = out_we;
    assign bus.out_addr  = out_we ? out_cnt    : '0;
    assign bus.out_wdata = out_we ? bus.pe_out : '0;
endmodule
